// File: rtl/nukv_result_pkg.sv
// nukv_result_pkg
// Shared types and constants for the predicate result merger:
//   - state_t : merger FSM states (IDLE / HDR / BODY)
//   - hdr_t   : latched header {meta, length, drop}
//   - BEAT_BYTES / BEAT_BYTES_LOG2 : bytes per value beat at the default width
package nukv_result_pkg;

    localparam int DEF_MEMORY_WIDTH = 512;
    localparam int DEF_META_WIDTH   = 96;
    localparam int BEAT_BYTES       = DEF_MEMORY_WIDTH / 8;
    localparam int BEAT_BYTES_LOG2  = $clog2(BEAT_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEF_META_WIDTH-1:0] meta;
        logic [15:0]               length;
        logic                      drop;
    } hdr_t;

endpackage

// File: rtl/nukv_pred_result_merger_if.sv
// nukv_pred_result_merger_if
// Handshake bundle of the result merger: command in, value stream in,
// header out, forwarded beat stream out.
//   slave  : merger view (consumes cmd/value, produces hdr/out)
//   master : surrounding pipeline view
interface nukv_pred_result_merger_if #(
    parameter int MEMORY_WIDTH = 512,
    parameter int META_WIDTH   = 96
);
    logic                    cmd_valid;
    logic [15:0]             cmd_length;
    logic [META_WIDTH-1:0]   cmd_meta;
    logic                    cmd_ready;

    logic [MEMORY_WIDTH-1:0] value_data;
    logic                    value_valid;
    logic                    value_last;
    logic                    value_drop;
    logic                    value_ready;

    logic                    hdr_valid;
    logic [META_WIDTH-1:0]   hdr_meta;
    logic [15:0]             hdr_length;
    logic                    hdr_drop;
    logic                    hdr_ready;

    logic [MEMORY_WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_last;
    logic                    out_ready;

    modport slave (
        input  cmd_valid, cmd_length, cmd_meta,
        output cmd_ready,
        input  value_data, value_valid, value_last, value_drop,
        output value_ready,
        output hdr_valid, hdr_meta, hdr_length, hdr_drop,
        input  hdr_ready,
        output out_data, out_valid, out_last,
        input  out_ready
    );

    modport master (
        output cmd_valid, cmd_length, cmd_meta,
        input  cmd_ready,
        output value_data, value_valid, value_last, value_drop,
        input  value_ready,
        input  hdr_valid, hdr_meta, hdr_length, hdr_drop,
        output hdr_ready,
        input  out_data, out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/nukv_beat_len_calc.sv
// nukv_beat_len_calc
// Maps a byte length to the number of value beats it occupies:
// max(1, ceil(length / 2^BEAT_LOG2)), evaluated in 17 bits so the
// rounding add cannot overflow.
//   i_length : value length in bytes
//   o_beats  : expected beat count
module nukv_beat_len_calc
    import nukv_result_pkg::*;
#(
    parameter int BEAT_LOG2 = BEAT_BYTES_LOG2
) (
    input  logic [15:0] i_length,
    output logic [15:0] o_beats
);

    logic [16:0] w_sum;
    logic [16:0] w_beats;

    assign w_sum   = {1'b0, i_length} + 17'((1 << BEAT_LOG2) - 1);
    assign w_beats = w_sum >> BEAT_LOG2;
    // A zero-length value still carries one (empty) beat.
    assign o_beats = (w_beats == 17'd0) ? 16'd1 : w_beats[15:0];

endmodule

// File: rtl/nukv_pred_result_merger.sv
// nukv_pred_result_merger
// Pairs each command from the last predicate evaluator with its value
// stream, emits one header per value and then forwards (passed) or
// discards (dropped) the value beats. Keeps pass/drop statistics.
//
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   io_bus           : cmd / value / hdr / out handshake bundle (slave view)
//   o_stat_passed    : values forwarded (wraps)
//   o_stat_dropped   : values discarded (wraps)
//   o_error_length   : sticky beat-count mismatch flag
//
// Build option NUKV_RESULT_LEN_CHECK_EN: when defined, the consumed beat
// count of each value is compared with the count implied by its length;
// otherwise o_error_length is tied low and no check logic exists.
//
// state | meaning
// IDLE  | wait for command and first value beat together, accept command
// HDR   | present latched header until hdr_ready
// BODY  | forward or discard beats until the last-beat handshake
module nukv_pred_result_merger
    import nukv_result_pkg::*;
#(
    parameter int MEMORY_WIDTH = DEF_MEMORY_WIDTH,
    parameter int META_WIDTH   = DEF_META_WIDTH,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    nukv_pred_result_merger_if.slave io_bus,
    output logic [CNT_WIDTH-1:0]     o_stat_passed,
    output logic [CNT_WIDTH-1:0]     o_stat_dropped,
    output logic                     o_error_length
);

    state_t               r_state;
    hdr_t                 r_hdr;
    logic [CNT_WIDTH-1:0] r_passed;
    logic [CNT_WIDTH-1:0] r_dropped;

    logic w_run;
    logic w_cmd_hs;
    logic w_hdr_valid;
    logic w_body_pass;
    logic w_body_drop;
    logic w_beat_hs;
    logic w_last_hs;

    // Combinational outputs are gated by reset so every output reads 0
    // while reset is held, not only after the reset edge.
    assign w_run       = ~i_rst;
    assign w_cmd_hs    = w_run && (r_state == IDLE) && io_bus.cmd_valid && io_bus.value_valid;
    assign w_hdr_valid = w_run && (r_state == HDR);
    assign w_body_pass = w_run && (r_state == BODY) && !r_hdr.drop;
    assign w_body_drop = w_run && (r_state == BODY) && r_hdr.drop;

    assign io_bus.cmd_ready  = w_cmd_hs;
    assign io_bus.hdr_valid  = w_hdr_valid;
    assign io_bus.hdr_meta   = w_hdr_valid ? r_hdr.meta : {META_WIDTH{1'b0}};
    assign io_bus.hdr_length = w_hdr_valid ? r_hdr.length : 16'd0;
    assign io_bus.hdr_drop   = w_hdr_valid && r_hdr.drop;

    // Passed values are a zero-latency pass-through; dropped values are
    // drained at full rate regardless of the downstream.
    assign io_bus.value_ready = w_body_drop || (w_body_pass && io_bus.out_ready);
    assign io_bus.out_valid   = w_body_pass && io_bus.value_valid;
    assign io_bus.out_data    = w_body_pass ? io_bus.value_data : {MEMORY_WIDTH{1'b0}};
    assign io_bus.out_last    = w_body_pass && io_bus.value_last;

    assign w_beat_hs = io_bus.value_valid && io_bus.value_ready;
    assign w_last_hs = w_beat_hs && io_bus.value_last;

    assign o_stat_passed  = r_passed;
    assign o_stat_dropped = r_dropped;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_hdr     <= '0;
            r_passed  <= '0;
            r_dropped <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmd_hs) begin
                        r_hdr.meta   <= io_bus.cmd_meta;
                        r_hdr.length <= io_bus.value_drop ? 16'd0 : io_bus.cmd_length;
                        r_hdr.drop   <= io_bus.value_drop;
                        r_state      <= HDR;
                    end
                end
                HDR: begin
                    if (io_bus.hdr_ready) begin
                        r_state <= BODY;
                    end
                end
                BODY: begin
                    if (w_last_hs) begin
                        if (r_hdr.drop) begin
                            r_dropped <= r_dropped + CNT_WIDTH'(1);
                        end else begin
                            r_passed <= r_passed + CNT_WIDTH'(1);
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef NUKV_RESULT_LEN_CHECK_EN
    logic [15:0] w_exp_beats;
    logic [15:0] w_cnt_next;
    logic [15:0] r_exp_beats;
    logic [15:0] r_beat_cnt;
    logic        r_err;

    nukv_beat_len_calc #(
        .BEAT_LOG2 ($clog2(MEMORY_WIDTH / 8))
    ) u_len_calc (
        .i_length (io_bus.cmd_length),
        .o_beats  (w_exp_beats)
    );

    // Saturating count: a runaway value must not wrap back into a match.
    assign w_cnt_next = (r_beat_cnt == 16'hFFFF) ? r_beat_cnt : r_beat_cnt + 16'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_exp_beats <= '0;
            r_beat_cnt  <= '0;
            r_err       <= 1'b0;
        end else if (w_cmd_hs) begin
            r_exp_beats <= w_exp_beats;
            r_beat_cnt  <= '0;
        end else if (w_beat_hs) begin
            r_beat_cnt <= w_cnt_next;
            if (io_bus.value_last && (w_cnt_next != r_exp_beats)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_error_length = r_err;
`else
    assign o_error_length = 1'b0;
`endif

endmodule

// File: tb/tb_nukv_pred_result_merger.sv
// tb_nukv_pred_result_merger
// Directed table of values (pass/drop, back-pressure, inputs arriving
// apart, length mismatch), a randomized phase checked against a
// transaction-level model, and a reset-mid-value sequence.
module tb_nukv_pred_result_merger;

    localparam int MW = 512;
    localparam int XW = 96;
    localparam int CW = 32;
    localparam int BB = MW / 8;
`ifdef NUKV_RESULT_LEN_CHECK_EN
    localparam bit LC = 1'b1;
`else
    localparam bit LC = 1'b0;
`endif

    typedef struct {
        int            len;
        logic [XW-1:0] meta;
        bit            drop;
        int            nb;
        int            lead;
        int            hw;
        bit            tg;
        int            exp_len;
        bit            exp_drop;
        bit            exp_err;
    } vec_t;

    typedef struct {
        logic [XW-1:0] meta;
        logic [15:0]   len;
        bit            drop;
    } hdr_rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] stat_passed;
    logic [CW-1:0] stat_dropped;
    logic          error_length;

    int            n_total = 0;
    int            n_pass  = 0;
    logic [CW-1:0] m_passed  = '0;
    logic [CW-1:0] m_dropped = '0;
    bit            m_err     = 1'b0;

    nukv_pred_result_merger_if #(.MEMORY_WIDTH(MW), .META_WIDTH(XW)) bus();

    nukv_pred_result_merger #(
        .MEMORY_WIDTH (MW),
        .META_WIDTH   (XW),
        .CNT_WIDTH    (CW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .io_bus         (bus),
        .o_stat_passed  (stat_passed),
        .o_stat_dropped (stat_dropped),
        .o_error_length (error_length)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_beats(input int len);
        return (len == 0) ? 1 : (len + BB - 1) / BB;
    endfunction

    function automatic logic [511:0] pat(input int row, input int i);
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'(row * 1000 + i * 16 + k) ^ 32'hA5A50000;
        return d;
    endfunction

    task automatic idle_inputs();
        bus.cmd_valid   = 1'b0;
        bus.cmd_length  = '0;
        bus.cmd_meta    = '0;
        bus.value_valid = 1'b0;
        bus.value_data  = '0;
        bus.value_last  = 1'b0;
        bus.value_drop  = 1'b0;
        bus.hdr_ready   = 1'b0;
        bus.out_ready   = 1'b0;
    endtask

    // Entered and left just after a rising edge with idle inputs.
    task automatic do_value(input vec_t v, input int row);
        int bi;
        int guard;
        bit hs;
        if (v.lead > 0) begin
            bus.cmd_valid = 1'b1; bus.cmd_length = 16'(v.len); bus.cmd_meta = v.meta;
            for (int i = 0; i < v.lead; i++) begin
                @(negedge clk); chk("cmd_ready_wait_value", bus.cmd_ready, 0); tick();
            end
        end else if (v.lead < 0) begin
            bus.value_valid = 1'b1; bus.value_data = pat(row, 0);
            bus.value_last = (v.nb == 1); bus.value_drop = v.drop;
            for (int i = 0; i < -v.lead; i++) begin
                @(negedge clk);
                chk("cmd_ready_wait_cmd", bus.cmd_ready, 0);
                chk("value_ready_idle_wait", bus.value_ready, 0);
                tick();
            end
        end
        bus.cmd_valid = 1'b1; bus.cmd_length = 16'(v.len); bus.cmd_meta = v.meta;
        bus.value_valid = 1'b1; bus.value_data = pat(row, 0);
        bus.value_last = (v.nb == 1); bus.value_drop = v.drop;
        @(negedge clk);
        chk("cmd_ready", bus.cmd_ready, 1);
        chk("value_ready_idle", bus.value_ready, 0);
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < v.hw; i++) begin
            @(negedge clk);
            chk("hdr_hold_valid", bus.hdr_valid, 1);
            chk("hdr_hold_meta", bus.hdr_meta, v.meta);
            chk("hdr_hold_length", bus.hdr_length, v.exp_len);
            tick();
        end
        bus.hdr_ready = 1'b1;
        @(negedge clk);
        chk("hdr_valid", bus.hdr_valid, 1);
        chk("hdr_meta", bus.hdr_meta, v.meta);
        chk("hdr_length", bus.hdr_length, v.exp_len);
        chk("hdr_drop", bus.hdr_drop, v.exp_drop);
        tick();
        bus.hdr_ready = 1'b0;
        bi = 0;
        guard = 0;
        while (bi < v.nb && guard < 64) begin
            bus.value_data = pat(row, bi);
            bus.value_last = (bi == v.nb - 1);
            bus.value_drop = (bi == 0) ? v.drop : ~v.drop;
            bus.out_ready  = v.tg ? (guard % 2 == 0) : 1'b1;
            @(negedge clk);
            chk("value_ready", bus.value_ready, v.drop ? 1'b1 : bus.out_ready);
            chk("out_valid", bus.out_valid, !v.drop);
            if (!v.drop) begin
                chk("out_data", bus.out_data, pat(row, bi));
                chk("out_last", bus.out_last, bi == v.nb - 1);
            end
            hs = bus.value_valid && bus.value_ready;
            tick();
            if (hs) bi++;
            guard++;
        end
        chk("beats_consumed", bi, v.nb);
        idle_inputs();
        if (v.drop) m_dropped++;
        else m_passed++;
        if (LC && v.nb != exp_beats(v.len)) m_err = 1'b1;
        @(negedge clk);
        chk("stat_passed", stat_passed, m_passed);
        chk("stat_dropped", stat_dropped, m_dropped);
        chk("error_length", error_length, v.exp_err);
        chk("idle_value_ready", bus.value_ready, 0);
        tick();
    endtask

    task automatic run_random(input int nt);
        hdr_rec_t      exp_hdr_q[$];
        logic [512:0]  exp_out_q[$];
        logic [XW-1:0] c_meta[$];
        logic [15:0]   c_len[$];
        logic [511:0]  b_data[$];
        bit            b_last[$];
        bit            b_drop[$];
        int ci, vi, hseen, oseen, cyc, nb, len, n_out, n_beats;
        bit drop, hold, hs_c, hs_v;
        logic [511:0] d;
        hdr_rec_t h;
        for (int t = 0; t < nt; t++) begin
            len  = $urandom_range(0, 700);
            drop = bit'($urandom_range(0, 1));
            nb   = exp_beats(len);
            case ($urandom_range(0, 7))
                0: nb = nb + 1;
                1: if (nb > 1) nb = nb - 1;
                default: ;
            endcase
            h.meta = {$urandom, $urandom, $urandom};
            h.len  = drop ? 16'd0 : 16'(len);
            h.drop = drop;
            exp_hdr_q.push_back(h);
            c_meta.push_back(h.meta);
            c_len.push_back(16'(len));
            for (int b = 0; b < nb; b++) begin
                for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
                b_data.push_back(d);
                b_last.push_back(b == nb - 1);
                b_drop.push_back((b == 0) ? drop : bit'($urandom_range(0, 1)));
                if (!drop) exp_out_q.push_back({b == nb - 1, d});
            end
            if (drop) m_dropped++;
            else m_passed++;
            if (LC && nb != exp_beats(len)) m_err = 1'b1;
        end
        n_out = exp_out_q.size();
        n_beats = b_data.size();
        ci = 0; vi = 0; hseen = 0; oseen = 0; cyc = 0; hold = 1'b0;
        while ((hseen < nt || oseen < n_out || vi < n_beats) && cyc < 20000) begin
            if (!bus.cmd_valid && ci < nt && $urandom_range(0, 3) != 0) begin
                bus.cmd_valid = 1'b1; bus.cmd_length = c_len[ci]; bus.cmd_meta = c_meta[ci];
            end
            if (!bus.value_valid && vi < n_beats && $urandom_range(0, 3) != 0) begin
                bus.value_valid = 1'b1; bus.value_data = b_data[vi];
                bus.value_last = b_last[vi]; bus.value_drop = b_drop[vi];
            end
            bus.hdr_ready = ($urandom_range(0, 2) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (hold && hseen < nt) begin
                chk("rnd_hdr_hold_valid", bus.hdr_valid, 1);
                chk("rnd_hdr_hold_meta", bus.hdr_meta, exp_hdr_q[hseen].meta);
            end
            hold = 1'b0;
            if (bus.hdr_valid) begin
                if (hseen >= nt) chk("rnd_hdr_extra", 1, 0);
                else if (bus.hdr_ready) begin
                    chk("rnd_hdr_meta", bus.hdr_meta, exp_hdr_q[hseen].meta);
                    chk("rnd_hdr_length", bus.hdr_length, exp_hdr_q[hseen].len);
                    chk("rnd_hdr_drop", bus.hdr_drop, exp_hdr_q[hseen].drop);
                    hseen++;
                end else hold = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (oseen < n_out) begin
                    chk("rnd_out_data", bus.out_data, exp_out_q[oseen][511:0]);
                    chk("rnd_out_last", bus.out_last, exp_out_q[oseen][512]);
                end else chk("rnd_out_extra", 1, 0);
                oseen++;
            end
            hs_c = bus.cmd_valid && bus.cmd_ready;
            hs_v = bus.value_valid && bus.value_ready;
            tick();
            if (hs_c) begin bus.cmd_valid = 1'b0; ci++; end
            if (hs_v) begin bus.value_valid = 1'b0; vi++; end
            cyc++;
        end
        chk("rnd_complete", (hseen == nt) && (oseen == n_out) && (vi == n_beats), 1);
        idle_inputs();
        @(negedge clk);
        chk("rnd_stat_passed", stat_passed, m_passed);
        chk("rnd_stat_dropped", stat_dropped, m_dropped);
        chk("rnd_error_length", error_length, m_err);
        tick();
    endtask

    initial begin
        vec_t vecs[8];
        vec_t g;
        vecs[0] = '{150, 96'hA5,   1'b0, 3,  0, 0, 1'b0, 150, 1'b0, 1'b0};
        vecs[1] = '{100, 96'h1234, 1'b1, 2,  0, 0, 1'b0, 0,   1'b1, 1'b0};
        vecs[2] = '{256, 96'hBEEF, 1'b0, 4,  0, 5, 1'b1, 256, 1'b0, 1'b0};
        vecs[3] = '{10,  96'h42,   1'b0, 1,  8, 0, 1'b0, 10,  1'b0, 1'b0};
        vecs[4] = '{200, 96'h43,   1'b0, 4, -8, 0, 1'b0, 200, 1'b0, 1'b0};
        vecs[5] = '{0,   96'h99,   1'b0, 1,  0, 0, 1'b0, 0,   1'b0, 1'b0};
        vecs[6] = '{300, 96'h55,   1'b1, 5,  0, 2, 1'b1, 0,   1'b1, 1'b0};
        vecs[7] = '{64,  96'h77,   1'b0, 2,  0, 0, 1'b0, 64,  1'b0, LC};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_hdr_valid", bus.hdr_valid, 0);
        chk("rst_value_ready", bus.value_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_stat_passed", stat_passed, 0);
        chk("rst_stat_dropped", stat_dropped, 0);
        chk("rst_error_length", error_length, 0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) do_value(vecs[i], i);
        for (int k = 1; k <= 10; k++) begin
            g = '{64 * k, 96'(k) + 96'hC000, 1'b0, k, 0, 0, 1'b0, 64 * k, 1'b0, LC};
            do_value(g, 100 + k);
        end

        run_random(40);

        // Reset during beat 2 of a 4-beat passed value.
        bus.cmd_valid = 1'b1; bus.cmd_length = 16'd256; bus.cmd_meta = 96'hDD;
        bus.value_valid = 1'b1; bus.value_data = pat(200, 0);
        bus.value_last = 1'b0; bus.value_drop = 1'b0;
        @(negedge clk); chk("mid_cmd_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0; bus.hdr_ready = 1'b1;
        @(negedge clk); chk("mid_hdr_valid", bus.hdr_valid, 1);
        tick();
        bus.hdr_ready = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk); chk("mid_beat1_valid", bus.out_valid, 1);
        tick();
        bus.value_data = pat(200, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_value_ready", bus.value_ready, 0);
        tick();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("post_rst_hdr_valid", bus.hdr_valid, 0);
        chk("post_rst_out_valid", bus.out_valid, 0);
        chk("post_rst_value_ready", bus.value_ready, 0);
        chk("post_rst_stat_passed", stat_passed, 0);
        chk("post_rst_stat_dropped", stat_dropped, 0);
        chk("post_rst_error_length", error_length, 0);
        m_passed = '0; m_dropped = '0; m_err = 1'b0;
        tick();
        g = '{0, 96'h3C, 1'b0, 1, 0, 0, 1'b0, 0, 1'b0, 1'b0};
        do_value(g, 300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
